// File: rtl/kontrolli_pkg.sv
// Shared definitions for the multicycle control unit:
// state codes, opcodes, ALU/PC select encodings and the control bundle.
package kontrolli_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_WB_MEM = 4'd4,
    S_MEM_WR = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_EXEC_I = 4'd8,
    S_WB_I   = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_ANDI  = 4'b0101;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1100;
  localparam logic [3:0] OP_BEQ   = 4'b0010;
  localparam logic [3:0] OP_J     = 4'b0111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  typedef struct packed {
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic       regwrite;
    logic       memtoreg;
    logic [1:0] pcsource;
    logic       gabim;
  } ctrl_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_ANDI,
      OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
      default:                    op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/kontrolli_dekoderi.sv
// State-to-control decode: ports state, memgati, opcode, is_and -> ctrl.
// Opcode only matters in DECODE (illegal flag); is_and is latched upstream.
module kontrolli_dekoderi
  import kontrolli_pkg::*;
(
  input  state_t     state,
  input  logic       memgati,
  input  logic [3:0] opcode,
  input  logic       is_and,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALU_ADD;
        ctrl.pcsource = PC_ALU;
        ctrl.irwrite = memgati;
        ctrl.pcwrite = memgati;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_BOFF;
        ctrl.aluop   = ALU_ADD;
        ctrl.gabim   = ~op_legal(opcode);
      end
      S_ADDR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_WB_R: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_EXEC_I: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = is_and ? ALU_AND : ALU_ADD;
      end
      S_WB_I: begin
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_REG;
        ctrl.aluop       = ALU_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/kontrolli_multicikel.sv
// Multicycle control FSM: state register and next-state logic.
// In: Clock, Reset, Opcode, Zero, MemGati. Out: datapath controls, Gabim, Gjendja.
module kontrolli_multicikel
  import kontrolli_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                MemGati,
  output logic                RegDst,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                RegWrite,
  output logic                MemToReg,
  output logic [1:0]          PCSource,
  output logic                Gabim,
  output logic [3:0]          Gjendja
);

  state_t     state_q;
  state_t     state_d;
  logic       and_q;
  logic [3:0] op;
  ctrl_t      ctrl;

  // Branch resolution happens in the datapath via PCWriteCond.
  logic unused_zero;
  assign unused_zero = Zero;

  assign op = 4'(Opcode);

  // EXEC_I needs to know ANDI vs ADDI; capture it in DECODE so
  // opcode changes after DECODE cannot disturb the ALU op.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_FETCH;
      and_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        and_q <= (op == OP_ANDI);
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:
        state_d = MemGati ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI: state_d = S_EXEC_I;
          OP_LW, OP_SW:    state_d = S_ADDR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_ADDR: begin
        if (op == OP_LW)
          state_d = S_MEM_RD;
        else if (op == OP_SW)
          state_d = S_MEM_WR;
        else
          state_d = S_FETCH;
      end
      S_MEM_RD:
        state_d = MemGati ? S_WB_MEM : S_MEM_RD;
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR:
        state_d = MemGati ? S_FETCH : S_MEM_WR;
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_EXEC_I: state_d = S_WB_I;
      S_WB_I:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  kontrolli_dekoderi u_dek (
    .state   (state_q),
    .memgati (MemGati),
    .opcode  (op),
    .is_and  (and_q),
    .ctrl    (ctrl)
  );

  assign RegDst      = ctrl.regdst;
  assign ALUSrcA     = ctrl.alusrca;
  assign ALUSrcB     = ctrl.alusrcb;
  assign ALUOp       = ctrl.aluop;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.memread;
  assign MemWrite    = ctrl.memwrite;
  assign IRWrite     = ctrl.irwrite;
  assign PCWrite     = ctrl.pcwrite;
  assign PCWriteCond = ctrl.pcwritecond;
  assign RegWrite    = ctrl.regwrite;
  assign MemToReg    = ctrl.memtoreg;
  assign PCSource    = ctrl.pcsource;
  assign Gabim       = ctrl.gabim;
  assign Gjendja     = state_q;

endmodule

// File: tb/tb_kontrolli_multicikel.sv
// Scoreboard bench for kontrolli_multicikel: per-cycle expected state
// and control vector queued at drive time, popped and compared at sample.
module tb_kontrolli_multicikel;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] Opcode;
  logic       Zero;
  logic       MemGati;
  logic       RegDst, ALUSrcA, IorD, MemRead, MemWrite;
  logic       IRWrite, PCWrite, PCWriteCond, RegWrite, MemToReg, Gabim;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] Gjendja;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] outs;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  kontrolli_multicikel #(.OPCODE_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .MemGati(MemGati), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .PCSource(PCSource), .Gabim(Gabim), .Gjendja(Gjendja)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", tag, got[16:0], exp[16:0]);
    end
  endtask

  // Expected control vector for a state, written from the state table.
  function automatic exp_t mk(input logic [3:0] st, input logic mg,
                              input logic [3:0] op, input logic andi);
    logic rd, sa, iod, mr, mw, irw, pcw, pcc, rw, m2r, gb;
    logic [1:0] sb_, ao, pcs;
    exp_t e;
    {rd, sa, iod, mr, mw, irw, pcw, pcc, rw, m2r, gb} = '0;
    sb_ = 2'b00; ao = 2'b00; pcs = 2'b00;
    case (st)
      4'd0:  begin mr = 1; sb_ = 2'b01; irw = mg; pcw = mg; end
      4'd1:  begin
        sb_ = 2'b11;
        gb = !(op inside {4'b0000, 4'b0100, 4'b0101, 4'b1000,
                          4'b1100, 4'b0010, 4'b0111});
      end
      4'd2:  begin sa = 1; sb_ = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iod = 1; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; sb_ = 2'b10; ao = andi ? 2'b11 : 2'b00; end
      4'd9:  begin rw = 1; end
      4'd10: begin sa = 1; ao = 2'b01; pcc = 1; pcs = 2'b01; end
      4'd11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    e.st = st;
    e.outs = {rd, sa, sb_, ao, iod, mr, mw, irw, pcw, pcc, rw, m2r, pcs, gb};
    return e;
  endfunction

  // One cycle: drive inputs, queue expectation, sample, step to next cycle.
  task automatic cyc(input logic mg, input logic [3:0] op,
                     input logic [3:0] st, input logic andi);
    exp_t e;
    logic [16:0] outs;
    MemGati = mg;
    Opcode  = op;
    sb.push_back(mk(st, mg, op, andi));
    #1;
    e = sb.pop_front();
    outs = {RegDst, ALUSrcA, ALUSrcB, ALUOp, IorD, MemRead, MemWrite,
            IRWrite, PCWrite, PCWriteCond, RegWrite, MemToReg,
            PCSource, Gabim};
    chk($sformatf("state@%0d", st), 32'(Gjendja), 32'(e.st));
    chk($sformatf("ctrl@%0d", st), 32'(outs), 32'(e.outs));
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1; MemGati = 1'b0; Opcode = 4'b0000; Zero = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    // reset state with memory not ready, then R-type
    cyc(0, 4'b0000, 4'd0, 0);
    cyc(1, 4'b0000, 4'd0, 0);
    cyc(1, 4'b0000, 4'd1, 0);
    cyc(1, 4'b0000, 4'd6, 0);
    cyc(1, 4'b0000, 4'd7, 0);

    // LW with two wait cycles in MEM_RD
    cyc(1, 4'b1000, 4'd0, 0);
    cyc(1, 4'b1000, 4'd1, 0);
    cyc(1, 4'b1000, 4'd2, 0);
    cyc(0, 4'b1000, 4'd3, 0);
    cyc(0, 4'b1000, 4'd3, 0);
    cyc(1, 4'b1000, 4'd3, 0);
    cyc(1, 4'b0000, 4'd4, 0);

    // SW, opcode noise in MEM_WR
    cyc(1, 4'b1100, 4'd0, 0);
    cyc(1, 4'b1100, 4'd1, 0);
    cyc(1, 4'b1100, 4'd2, 0);
    cyc(1, 4'b1000, 4'd5, 0);

    // BEQ taken and not taken
    Zero = 1'b1;
    cyc(1, 4'b0010, 4'd0, 0);
    cyc(1, 4'b0010, 4'd1, 0);
    cyc(1, 4'b0010, 4'd10, 0);
    Zero = 1'b0;
    cyc(1, 4'b0010, 4'd0, 0);
    cyc(1, 4'b0010, 4'd1, 0);
    cyc(1, 4'b0010, 4'd10, 0);

    // illegal opcode
    cyc(1, 4'b1111, 4'd0, 0);
    cyc(1, 4'b1111, 4'd1, 0);

    // ANDI, opcode flips to ADDI in EXEC_I without effect
    cyc(1, 4'b0101, 4'd0, 0);
    cyc(1, 4'b0101, 4'd1, 0);
    cyc(1, 4'b0100, 4'd8, 1);
    cyc(1, 4'b0100, 4'd9, 1);

    // ADDI
    cyc(1, 4'b0100, 4'd0, 0);
    cyc(1, 4'b0100, 4'd1, 0);
    cyc(1, 4'b0101, 4'd8, 0);
    cyc(1, 4'b0100, 4'd9, 0);

    // jump
    cyc(1, 4'b0111, 4'd0, 0);
    cyc(1, 4'b0111, 4'd1, 0);
    cyc(1, 4'b0000, 4'd11, 0);

    // reset while waiting in MEM_WR
    cyc(1, 4'b1100, 4'd0, 0);
    cyc(1, 4'b1100, 4'd1, 0);
    cyc(1, 4'b1100, 4'd2, 0);
    cyc(0, 4'b1100, 4'd5, 0);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    cyc(0, 4'b1100, 4'd0, 0);
    cyc(1, 4'b1111, 4'd0, 0);
    cyc(1, 4'b1111, 4'd1, 0);
    cyc(0, 4'b0000, 4'd0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
